micro_sequencer: RTL and testbench

- Next-address unit for the microprogrammed multicycle controller. Holds the micro-program counter (uPC) that addresses the control store.
- Each cycle it selects the next uPC from the current microword's 2-bit sequencing field (`choice`) and the instruction opcode (`op`). Available choices: sequential, dispatch 1, dispatch 2, or back to fetch.
- Also stalls on memory wait, flags illegal opcodes, and counts retired instructions.

---
 rtl/micro_sequencer_if.sv | 25 ++
 rtl/micro_sequencer.sv | 97 +++++++++
 tb/tb_micro_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// Sequencing bus between the microcode control store and micro_sequencer.
// Master drives the microword/opcode fields; slave returns uPC and status.
interface micro_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic [5:0]        op;
  logic [1:0]        choice;
  logic              wait_mem;
  logic              mem_ready;
  logic [ADDR_W-1:0] upc;
  logic              stall;
  logic              illegal;
  logic [CNT_W-1:0]  retired;

  modport master (
    output op, choice, wait_mem, mem_ready,
    input  upc, stall, illegal, retired
  );

  modport slave (
    input  op, choice, wait_mem, mem_ready,
    output upc, stall, illegal, retired
  );
endinterface

// File: rtl/micro_sequencer.sv
// Next-address unit for the microprogrammed multicycle controller.
// Registers the uPC, flags unmapped dispatches, counts retired instrs.
module micro_sequencer #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input logic             clock,
  input logic             reset,
  micro_sequencer_if.slave bus
);

  localparam logic [1:0] CH_SEQ   = 2'b00;
  localparam logic [1:0] CH_DISP1 = 2'b01;
  localparam logic [1:0] CH_DISP2 = 2'b10;
  localparam logic [1:0] CH_FETCH = 2'b11;

  logic [ADDR_W-1:0] upc_q;
  logic              ill_q;
  logic [CNT_W-1:0]  ret_q;

  logic              stall;
  logic              hit1;
  logic              hit2;
  logic [7:0]        tgt1;
  logic [7:0]        tgt2;
  logic [ADDR_W-1:0] upc_d;
  logic              ill_d;
  logic              ret_inc;

  assign stall = bus.wait_mem & ~bus.mem_ready;

  always_comb begin
    hit1 = 1'b1;
    tgt1 = 8'd0;
    unique case (bus.op)
      6'h00:   tgt1 = 8'd6;
      6'h23:   tgt1 = 8'd2;
      6'h2B:   tgt1 = 8'd2;
      6'h04:   tgt1 = 8'd8;
      6'h02:   tgt1 = 8'd9;
      6'h08:   tgt1 = 8'd10;
      default: hit1 = 1'b0;
    endcase
  end

  always_comb begin
    hit2 = 1'b1;
    tgt2 = 8'd0;
    unique case (bus.op)
      6'h23:   tgt2 = 8'd3;
      6'h2B:   tgt2 = 8'd5;
      default: hit2 = 1'b0;
    endcase
  end

  // Unmapped dispatches restart at fetch and raise illegal.
  always_comb begin
    upc_d   = upc_q;
    ill_d   = 1'b0;
    ret_inc = 1'b0;
    if (!stall) begin
      unique case (bus.choice)
        CH_SEQ: upc_d = upc_q + ADDR_W'(1);
        CH_DISP1: begin
          upc_d = hit1 ? ADDR_W'(tgt1) : '0;
          ill_d = ~hit1;
        end
        CH_DISP2: begin
          upc_d = hit2 ? ADDR_W'(tgt2) : '0;
          ill_d = ~hit2;
        end
        CH_FETCH: begin
          upc_d   = '0;
          ret_inc = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upc_q <= '0;
      ill_q <= 1'b0;
      ret_q <= '0;
    end else begin
      upc_q <= upc_d;
      ill_q <= ill_d;
      if (ret_inc) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign bus.upc     = upc_q;
  assign bus.illegal = ill_q;
  assign bus.retired = ret_q;
  assign bus.stall   = stall;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: vector table, microprogram
// runs, reset/wrap corners and random stimulus against a reference model.
module tb_micro_sequencer;

  logic clock;
  logic reset;
  logic reset2;

  micro_sequencer_if #(.ADDR_W(4), .CNT_W(16)) bus ();
  micro_sequencer_if #(.ADDR_W(4), .CNT_W(2))  bus2 ();

  micro_sequencer #(.ADDR_W(4), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  micro_sequencer #(.ADDR_W(4), .CNT_W(2)) dut2 (
    .clock (clock),
    .reset (reset2),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nchk;
  int nerr;

  int m_upc;
  int m_ret;
  int m_ill;

  int d1_op[6] = '{'h00, 'h23, 'h2B, 'h04, 'h02, 'h08};
  int d1_tg[6] = '{6, 2, 2, 8, 9, 10};
  int d2_op[2] = '{'h23, 'h2B};
  int d2_tg[2] = '{3, 5};

  logic [1:0] rom_ch[16];
  logic       rom_w[16];

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  ch;
    logic        w;
    logic        r;
    logic        e_stall;
    logic [3:0]  e_upc;
    logic        e_ill;
    logic [15:0] e_ret;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input int which, input int o, output bit hit);
    hit = 1'b0;
    lookup = 0;
    if (which == 1) begin
      foreach (d1_op[i]) if (d1_op[i] == o) begin hit = 1'b1; lookup = d1_tg[i]; end
    end else begin
      foreach (d2_op[i]) if (d2_op[i] == o) begin hit = 1'b1; lookup = d2_tg[i]; end
    end
  endfunction

  task automatic model_reset();
    m_upc = 0;
    m_ret = 0;
    m_ill = 0;
  endtask

  task automatic model_step(input int o, input int c, input bit w, input bit r);
    bit hit;
    int t;
    m_ill = 0;
    if (w && !r) return;
    case (c)
      0: m_upc = (m_upc + 1) % 16;
      1, 2: begin
        t = lookup(c, o, hit);
        m_upc = hit ? t % 16 : 0;
        m_ill = hit ? 0 : 1;
      end
      default: begin
        m_upc = 0;
        m_ret = (m_ret + 1) % 65536;
      end
    endcase
  endtask

  task automatic step(input logic [5:0] o, input logic [1:0] c,
                      input logic w, input logic r);
    bus.op        = o;
    bus.choice    = c;
    bus.wait_mem  = w;
    bus.mem_ready = r;
    #1;
    chk("stall", int'(bus.stall), int'(w & ~r));
    @(posedge clock);
    model_step(int'(o), int'(c), w, r);
    #1;
    chk("upc", int'(bus.upc), m_upc);
    chk("illegal", int'(bus.illegal), m_ill);
    chk("retired", int'(bus.retired), m_ret);
  endtask

  task automatic run_prog(input logic [5:0] o, input int n,
                          input logic [31:0] path);
    chk("path_start", int'(bus.upc), int'(path[3:0]));
    for (int i = 1; i < n; i++) begin
      step(o, rom_ch[m_upc], rom_w[m_upc], 1'b1);
      chk("path", int'(bus.upc), int'(path[4*i +: 4]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    reset = 1'b1;
    reset2 = 1'b1;
    bus.op = 6'h00;
    bus.choice = 2'b00;
    bus.wait_mem = 1'b0;
    bus.mem_ready = 1'b0;
    bus2.op = 6'h00;
    bus2.choice = 2'b11;
    bus2.wait_mem = 1'b0;
    bus2.mem_ready = 1'b0;
    model_reset();

    for (int a = 0; a < 16; a++) begin
      rom_ch[a] = 2'b00;
      rom_w[a]  = 1'b0;
    end
    rom_w[0] = 1'b1;
    rom_ch[1] = 2'b01;
    rom_ch[2] = 2'b10;
    rom_w[3] = 1'b1;
    rom_ch[4] = 2'b11;
    rom_w[5] = 1'b1;
    rom_ch[5] = 2'b11;
    rom_ch[7] = 2'b11;
    rom_ch[8] = 2'b11;
    rom_ch[9] = 2'b11;
    rom_ch[11] = 2'b11;

    tbl[0]  = '{6'h23, 2'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 16'd0};
    tbl[1]  = '{6'h23, 2'd1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 16'd0};
    tbl[2]  = '{6'h23, 2'd2, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 16'd0};
    tbl[3]  = '{6'h23, 2'd0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 16'd0};
    tbl[4]  = '{6'h23, 2'd3, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'd1};
    tbl[5]  = '{6'h23, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 16'd1};
    tbl[6]  = '{6'h23, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 16'd1};
    tbl[7]  = '{6'h23, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 16'd1};
    tbl[8]  = '{6'h23, 2'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 16'd1};
    tbl[9]  = '{6'h3F, 2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 16'd1};
    tbl[10] = '{6'h00, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 16'd1};
    tbl[11] = '{6'h3F, 2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 16'd1};
    tbl[12] = '{6'h2B, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 16'd1};
    tbl[13] = '{6'h23, 2'd1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 16'd1};
    tbl[14] = '{6'h23, 2'd1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 16'd1};

    #12;
    chk("reset_upc", int'(bus.upc), 0);
    chk("reset_ill", int'(bus.illegal), 0);
    chk("reset_ret", int'(bus.retired), 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].op, tbl[i].ch, tbl[i].w, tbl[i].r);
      chk("tbl_upc", int'(bus.upc), int'(tbl[i].e_upc));
      chk("tbl_ill", int'(bus.illegal), int'(tbl[i].e_ill));
      chk("tbl_ret", int'(bus.retired), int'(tbl[i].e_ret));
    end

    do_reset();
    run_prog(6'h2B, 5, 32'h05210);
    run_prog(6'h00, 5, 32'h07610);
    run_prog(6'h04, 4, 32'h00810);
    run_prog(6'h08, 5, 32'h0BA10);
    chk("retired_four", int'(bus.retired), 4);
    run_prog(6'h02, 4, 32'h00910);
    step(6'h00, 2'd0, 1'b1, 1'b1);
    step(6'h00, 2'd1, 1'b0, 1'b1);
    step(6'h00, 2'd0, 1'b0, 1'b1);
    chk("pre_reset_upc", int'(bus.upc), 7);
    chk("pre_reset_ret", int'(bus.retired), 5);

    #2;
    reset = 1'b1;
    #1;
    chk("async_upc", int'(bus.upc), 0);
    chk("async_ret", int'(bus.retired), 0);
    for (int k = 0; k < 2; k++) begin
      bus.choice = 2'b11;
      @(posedge clock);
      #1;
      chk("hold_upc", int'(bus.upc), 0);
      chk("hold_ret", int'(bus.retired), 0);
    end
    reset = 1'b0;
    model_reset();

    run_prog(6'h23, 6, 32'h043210);
    chk("lw_retired", int'(bus.retired), 1);

    for (int k = 0; k < 16; k++) step(6'h00, 2'd0, 1'b0, 1'b0);
    chk("wrap_upc", int'(bus.upc), 0);
    chk("wrap_ret", int'(bus.retired), 1);

    for (int k = 0; k < 400; k++) begin
      logic [5:0] o;
      if ($urandom_range(0, 9) < 6) o = 6'(d1_op[$urandom_range(0, 5)]);
      else o = 6'($urandom_range(0, 63));
      step(o, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end

    #2;
    reset2 = 1'b0;
    chk("cnt2_reset", int'(bus2.retired), 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
      chk("cnt2_wrap", int'(bus2.retired), k % 4);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
